// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter.
// Holds the active-low reset levels, the FSM state encoding, the arbitration
// mode selectors and the grant encoding used by mem_arbiter and mem_arb_pick.
package mem_arbiter_pkg;

  localparam logic RstNEnable  = 1'b0;
  localparam logic RstNDisable = 1'b1;

  typedef enum logic [1:0] {
    ArbIdle  = 2'b00,
    ArbServe = 2'b01,
    ArbResp  = 2'b10
  } arb_state_e;

  localparam int ArbModeFixed = 0;
  localparam int ArbModeRR    = 1;

  typedef enum logic {
    GntIf   = 1'b0,
    GntData = 1'b1
  } grant_e;

  // Fetch accesses are always full-word reads.
  localparam logic [3:0] SelAll = 4'b1111;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// Ports:
//   if_req, d_req  - current request lines
//   last_grant     - requester granted most recently (round-robin history)
//   grant          - selected requester
//   valid          - at least one request present, grant is meaningful
// ARB_MODE selects fixed priority (data wins) or round-robin on contention.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ArbModeFixed
) (
  input  logic   if_req,
  input  logic   d_req,
  input  grant_e last_grant,
  output grant_e grant,
  output logic   valid
);

  // A lone requester always wins; only contention consults the mode.
  always_comb begin
    grant = GntIf;
    valid = if_req | d_req;
    if (d_req && !if_req) begin
      grant = GntData;
    end else if (d_req && if_req) begin
      if (ARB_MODE == ArbModeRR) begin
        grant = (last_grant == GntIf) ? GntData : GntIf;
      end else begin
        grant = GntData;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one RAM port between instruction fetch and the data cache.
// One RAM transaction is sequenced at a time through IDLE -> SERVE -> RESP.
// Ports:
//   clk, rst                    - clock, asynchronous active-low reset
//   if_req_i/if_addr_i          - fetch request and word address
//   if_data_o/if_ready_o        - fetch read data and one-cycle completion
//   d_req_i/d_we_i/d_sel_i      - data request, write enable, byte enables
//   d_addr_i/d_data_i           - data address and write data
//   d_data_o/d_ready_o          - data read data and one-cycle completion
//   ram_ce_o/ram_we_o/ram_sel_o - RAM strobes, valid only in SERVE
//   ram_addr_o/ram_data_o       - RAM address and write data
//   ram_data_i/ram_data_ready   - RAM read data and completion
//   busy_o                      - transaction in flight (SERVE or RESP)
//   err_o                       - sticky timeout flag
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ArbModeFixed,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_data_i,
  output logic [31:0] d_data_o,
  output logic        d_ready_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i,
  input  logic        ram_data_ready,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] CntLimit = CNT_W'(TIMEOUT);

  arb_state_e       state;
  arb_state_e       state_next;
  grant_e           last_grant;
  grant_e           pick_grant;
  logic             pick_valid;
  logic             lat_we;
  logic [3:0]       lat_sel;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_hit;
  logic [31:0]      if_data_q;
  logic [31:0]      d_data_q;
  logic             err_q;

  mem_arb_pick #(
    .ARB_MODE(ARB_MODE)
  ) u_pick (
    .if_req    (if_req_i),
    .d_req     (d_req_i),
    .last_grant(last_grant),
    .grant     (pick_grant),
    .valid     (pick_valid)
  );

  // The counter saturates instead of wrapping; the abort fires on the SERVE
  // cycle whose increment reaches TIMEOUT, so SERVE lasts at most TIMEOUT cycles.
  assign cnt_inc = (cnt == CntMax) ? cnt : cnt + 1'b1;
  assign cnt_hit = (TIMEOUT != 0) && (cnt_inc == CntLimit);

  // Next state plus all strobes; RAM lines are only non-zero in SERVE and the
  // ready pulse is steered by the grant recorded when the transaction started.
  always_comb begin
    state_next = state;
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_sel_o  = 4'b0000;
    ram_addr_o = 32'h0;
    ram_data_o = 32'h0;
    if_ready_o = 1'b0;
    d_ready_o  = 1'b0;
    case (state)
      ArbIdle: begin
        if (pick_valid) state_next = ArbServe;
      end
      ArbServe: begin
        ram_ce_o   = 1'b1;
        ram_we_o   = lat_we;
        ram_sel_o  = lat_sel;
        ram_addr_o = lat_addr;
        ram_data_o = lat_wdata;
        if (ram_data_ready || cnt_hit) state_next = ArbResp;
      end
      ArbResp: begin
        if_ready_o = (last_grant == GntIf);
        d_ready_o  = (last_grant == GntData);
        state_next = ArbIdle;
      end
      default: state_next = ArbIdle;
    endcase
  end

  // State register, request latches, timeout counter and read-data holding
  // registers. Writes never disturb the data-side read register.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstNEnable) begin
      state      <= ArbIdle;
      last_grant <= GntIf;
      lat_we     <= 1'b0;
      lat_sel    <= 4'b0000;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      cnt        <= '0;
      if_data_q  <= 32'h0;
      d_data_q   <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ArbIdle: begin
          if (pick_valid) begin
            last_grant <= pick_grant;
            cnt        <= '0;
            if (pick_grant == GntData) begin
              lat_we    <= d_we_i;
              lat_sel   <= d_sel_i;
              lat_addr  <= d_addr_i;
              lat_wdata <= d_data_i;
            end else begin
              lat_we    <= 1'b0;
              lat_sel   <= SelAll;
              lat_addr  <= if_addr_i;
              lat_wdata <= 32'h0;
            end
          end
        end
        ArbServe: begin
          if (ram_data_ready) begin
            if (last_grant == GntIf) if_data_q <= ram_data_i;
            else if (!lat_we)        d_data_q  <= ram_data_i;
          end else begin
            cnt <= cnt_inc;
            if (cnt_hit) begin
              err_q <= 1'b1;
              if (last_grant == GntIf) if_data_q <= 32'h0;
              else if (!lat_we)        d_data_q  <= 32'h0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign if_data_o = if_data_q;
  assign d_data_o  = d_data_q;
  assign busy_o    = (state != ArbIdle);
  assign err_o     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Two instances share the clock and
// reset: index 0 uses fixed priority, index 1 round-robin, both TIMEOUT=4.
// A transaction-level model tracks pending requests, the arbitration rule,
// the read-data holding registers and the sticky error flag.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TimeoutCyc = 4;
  localparam int NumInst    = 2;
  localparam int RandIters  = 30;

  logic clk;
  logic rst;

  logic        if_req    [NumInst];
  logic [31:0] if_addr   [NumInst];
  logic [31:0] if_data   [NumInst];
  logic        if_ready  [NumInst];
  logic        d_req     [NumInst];
  logic        d_we      [NumInst];
  logic [3:0]  d_sel     [NumInst];
  logic [31:0] d_addr    [NumInst];
  logic [31:0] d_wdata   [NumInst];
  logic [31:0] d_rdata   [NumInst];
  logic        d_ready   [NumInst];
  logic        ram_ce    [NumInst];
  logic        ram_we    [NumInst];
  logic [3:0]  ram_sel   [NumInst];
  logic [31:0] ram_addr  [NumInst];
  logic [31:0] ram_wdata [NumInst];
  logic [31:0] ram_rdata [NumInst];
  logic        ram_rdy   [NumInst];
  logic        busy      [NumInst];
  logic        err       [NumInst];

  // Transaction-level reference state
  int          arbMode [NumInst];
  bit          mLastD  [NumInst];
  logic [31:0] mIfData [NumInst];
  logic [31:0] mDData  [NumInst];
  bit          mErr    [NumInst];
  bit          pIf     [NumInst];
  bit          pD      [NumInst];
  logic [31:0] pIfAddr [NumInst];
  logic        pDWe    [NumInst];
  logic [3:0]  pDSel   [NumInst];
  logic [31:0] pDAddr  [NumInst];
  logic [31:0] pDData  [NumInst];

  int checks;
  int passes;
  int curInst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter #(.ARB_MODE(ArbModeFixed), .TIMEOUT(TimeoutCyc), .CNT_W(8)) dut_fixed (
    .clk(clk), .rst(rst),
    .if_req_i(if_req[0]), .if_addr_i(if_addr[0]), .if_data_o(if_data[0]), .if_ready_o(if_ready[0]),
    .d_req_i(d_req[0]), .d_we_i(d_we[0]), .d_sel_i(d_sel[0]), .d_addr_i(d_addr[0]),
    .d_data_i(d_wdata[0]), .d_data_o(d_rdata[0]), .d_ready_o(d_ready[0]),
    .ram_ce_o(ram_ce[0]), .ram_we_o(ram_we[0]), .ram_sel_o(ram_sel[0]), .ram_addr_o(ram_addr[0]),
    .ram_data_o(ram_wdata[0]), .ram_data_i(ram_rdata[0]), .ram_data_ready(ram_rdy[0]),
    .busy_o(busy[0]), .err_o(err[0])
  );

  mem_arbiter #(.ARB_MODE(ArbModeRR), .TIMEOUT(TimeoutCyc), .CNT_W(8)) dut_rr (
    .clk(clk), .rst(rst),
    .if_req_i(if_req[1]), .if_addr_i(if_addr[1]), .if_data_o(if_data[1]), .if_ready_o(if_ready[1]),
    .d_req_i(d_req[1]), .d_we_i(d_we[1]), .d_sel_i(d_sel[1]), .d_addr_i(d_addr[1]),
    .d_data_i(d_wdata[1]), .d_data_o(d_rdata[1]), .d_ready_o(d_ready[1]),
    .ram_ce_o(ram_ce[1]), .ram_we_o(ram_we[1]), .ram_sel_o(ram_sel[1]), .ram_addr_o(ram_addr[1]),
    .ram_data_o(ram_wdata[1]), .ram_data_i(ram_rdata[1]), .ram_data_ready(ram_rdy[1]),
    .busy_o(busy[1]), .err_o(err[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL i%0d %s: observed %h, expected %h", curInst, tag, observed, expected);
  endtask

  task automatic applyStimulus(input int inst);
    if_req[inst]  = pIf[inst];
    if_addr[inst] = pIfAddr[inst];
    d_req[inst]   = pD[inst];
    d_we[inst]    = pDWe[inst];
    d_sel[inst]   = pDSel[inst];
    d_addr[inst]  = pDAddr[inst];
    d_wdata[inst] = pDData[inst];
  endtask

  task automatic newFetch(input int inst, input logic [31:0] addr);
    pIf[inst]     = 1'b1;
    pIfAddr[inst] = addr;
  endtask

  task automatic newData(input int inst, input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] data);
    pD[inst]     = 1'b1;
    pDWe[inst]   = we;
    pDSel[inst]  = sel;
    pDAddr[inst] = addr;
    pDData[inst] = data;
  endtask

  task automatic resetModels();
    for (int i = 0; i < NumInst; i++) begin
      mLastD[i]  = 1'b0;
      mIfData[i] = 32'h0;
      mDData[i]  = 32'h0;
      mErr[i]    = 1'b0;
      pIf[i]     = 1'b0;
      pD[i]      = 1'b0;
      pIfAddr[i] = 32'h0;
      pDWe[i]    = 1'b0;
      pDSel[i]   = 4'h0;
      pDAddr[i]  = 32'h0;
      pDData[i]  = 32'h0;
      applyStimulus(i);
      ram_rdy[i]   = 1'b0;
      ram_rdata[i] = 32'h0;
    end
  endtask

  task automatic checkReset(input int inst);
    curInst = inst;
    checkOutput("rst busy", 32'(busy[inst]), 0);
    checkOutput("rst err", 32'(err[inst]), 0);
    checkOutput("rst ram_ce", 32'(ram_ce[inst]), 0);
    checkOutput("rst ram_we", 32'(ram_we[inst]), 0);
    checkOutput("rst ram_sel", 32'(ram_sel[inst]), 0);
    checkOutput("rst ram_addr", ram_addr[inst], 0);
    checkOutput("rst ram_data", ram_wdata[inst], 0);
    checkOutput("rst readies", 32'({if_ready[inst], d_ready[inst]}), 0);
    checkOutput("rst if_data", if_data[inst], 0);
    checkOutput("rst d_data", d_rdata[inst], 0);
  endtask

  // Entered with requests driven and the DUT in IDLE; leaves at the RESP
  // sampling point. delay = SERVE cycles without ram_data_ready before it is
  // given; delay >= TimeoutCyc means it is never given.
  task automatic serveTxn(input int inst, input int delay, input logic [31:0] rdata);
    bit          winD;
    bit          tmo;
    int          nServe;
    logic        expWe;
    logic [3:0]  expSel;
    logic [31:0] expAddr;
    curInst = inst;
    if (pD[inst] && pIf[inst]) winD = (arbMode[inst] == ArbModeFixed) ? 1'b1 : !mLastD[inst];
    else                       winD = pD[inst];
    mLastD[inst] = winD;
    expWe   = winD ? pDWe[inst]   : 1'b0;
    expSel  = winD ? pDSel[inst]  : 4'hF;
    expAddr = winD ? pDAddr[inst] : pIfAddr[inst];
    tmo     = (delay >= TimeoutCyc);
    nServe  = tmo ? TimeoutCyc : delay + 1;
    @(posedge clk);
    for (int c = 1; c <= nServe; c++) begin
      @(negedge clk);
      checkOutput("serve busy", 32'(busy[inst]), 1);
      checkOutput("serve ram_ce", 32'(ram_ce[inst]), 1);
      checkOutput("serve ram_we", 32'(ram_we[inst]), 32'(expWe));
      checkOutput("serve ram_sel", 32'(ram_sel[inst]), 32'(expSel));
      checkOutput("serve ram_addr", ram_addr[inst], expAddr);
      if (expWe) checkOutput("serve ram_data", ram_wdata[inst], pDData[inst]);
      checkOutput("serve readies", 32'({if_ready[inst], d_ready[inst]}), 0);
      if (c == 1) begin
        // Requester fields move while held; the latched copy must not.
        if (winD) begin
          d_addr[inst]  = $urandom;
          d_wdata[inst] = $urandom;
          d_sel[inst]   = 4'($urandom_range(0, 15));
          d_we[inst]    = 1'($urandom_range(0, 1));
        end else begin
          if_addr[inst] = $urandom;
        end
      end
      ram_rdy[inst]   = (c == nServe) && !tmo;
      ram_rdata[inst] = ((c == nServe) && !tmo) ? rdata : $urandom;
      @(posedge clk);
    end
    @(negedge clk);
    if (tmo) begin
      mErr[inst] = 1'b1;
      if (!winD)          mIfData[inst] = 32'h0;
      else if (!expWe)    mDData[inst]  = 32'h0;
    end else begin
      if (!winD)          mIfData[inst] = rdata;
      else if (!expWe)    mDData[inst]  = rdata;
    end
    checkOutput("resp if_ready", 32'(if_ready[inst]), 32'(!winD));
    checkOutput("resp d_ready", 32'(d_ready[inst]), 32'(winD));
    checkOutput("resp if_data", if_data[inst], mIfData[inst]);
    checkOutput("resp d_data", d_rdata[inst], mDData[inst]);
    checkOutput("resp err", 32'(err[inst]), 32'(mErr[inst]));
    checkOutput("resp busy", 32'(busy[inst]), 1);
    checkOutput("resp ram_ce", 32'(ram_ce[inst]), 0);
    checkOutput("resp ram_we", 32'(ram_we[inst]), 0);
    checkOutput("resp ram_addr", ram_addr[inst], 0);
    // Spurious completion during RESP must be ignored.
    ram_rdy[inst]   = 1'($urandom_range(0, 1));
    ram_rdata[inst] = $urandom;
    if (winD) pD[inst] = 1'b0;
    else      pIf[inst] = 1'b0;
    applyStimulus(inst);
  endtask

  task automatic nextTxn(input int inst, input int delay, input logic [31:0] rdata);
    @(posedge clk);
    #1;
    applyStimulus(inst);
    ram_rdy[inst]   = 1'($urandom_range(0, 1));
    ram_rdata[inst] = $urandom;
    serveTxn(inst, delay, rdata);
  endtask

  // IDLE cycle with a stray ram_data_ready: no pulse, no data change.
  task automatic idleGap(input int inst);
    curInst = inst;
    @(posedge clk);
    #1;
    ram_rdy[inst]   = 1'b1;
    ram_rdata[inst] = $urandom;
    @(negedge clk);
    checkOutput("idle busy", 32'(busy[inst]), 0);
    checkOutput("idle readies", 32'({if_ready[inst], d_ready[inst]}), 0);
    checkOutput("idle if_data", if_data[inst], mIfData[inst]);
    checkOutput("idle d_data", d_rdata[inst], mDData[inst]);
  endtask

  task automatic randomTxn(input int inst);
    int delay;
    if (!pIf[inst] && $urandom_range(0, 1) == 1) newFetch(inst, $urandom);
    if (!pD[inst] && $urandom_range(0, 1) == 1)
      newData(inst, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
    if (!pIf[inst] && !pD[inst]) newFetch(inst, $urandom);
    if ($urandom_range(0, 9) < 8) delay = int'($urandom_range(0, 3));
    else                          delay = int'($urandom_range(TimeoutCyc, TimeoutCyc + 2));
    nextTxn(inst, delay, $urandom);
    if (!pIf[inst] && !pD[inst] && $urandom_range(0, 3) == 0) idleGap(inst);
  endtask

  task automatic resetMidServe(input int inst);
    curInst = inst;
    newFetch(inst, $urandom);
    @(posedge clk);
    #1;
    applyStimulus(inst);
    ram_rdy[inst] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("pre-reset busy", 32'(busy[inst]), 1);
    #2;
    rst = RstNEnable;
    #1;
    checkReset(inst);
    resetModels();
    @(negedge clk);
    curInst = inst;
    checkOutput("in-reset readies", 32'({if_ready[inst], d_ready[inst]}), 0);
    rst = RstNDisable;
    @(negedge clk);
    checkOutput("post-reset busy", 32'(busy[inst]), 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks     = 0;
    passes     = 0;
    curInst    = 0;
    arbMode[0] = ArbModeFixed;
    arbMode[1] = ArbModeRR;
    rst = RstNEnable;
    resetModels();
    repeat (2) @(negedge clk);
    for (int i = 0; i < NumInst; i++) checkReset(i);
    rst = RstNDisable;

    // Fetch-only read, RAM answers after two wait cycles
    newFetch(0, 32'h0000_0100);
    nextTxn(0, 2, 32'h3C01_0001);

    // Contention under fixed priority: the write goes first, fetch follows
    newData(0, 1'b1, 4'b0011, 32'h0000_0200, 32'hDEAD_BEEF);
    newFetch(0, 32'h0000_0104);
    nextTxn(0, 1, 32'h5555_AAAA);
    nextTxn(0, 0, 32'h2402_0005);

    // Round-robin with both requesters continuously asking
    for (int k = 0; k < 4; k++) begin
      if (!pIf[1]) newFetch(1, $urandom);
      if (!pD[1])  newData(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
      nextTxn(1, int'($urandom_range(0, 3)), $urandom);
    end
    pIf[1] = 1'b0;
    pD[1]  = 1'b0;
    applyStimulus(1);

    // Timeout on a data read, then a normal fetch with err still set
    newData(0, 1'b0, 4'hF, 32'h0000_0300, 32'h0);
    nextTxn(0, TimeoutCyc + 2, 32'h1234_5678);
    newFetch(0, 32'h0000_0108);
    nextTxn(0, 1, 32'h1111_2222);
    idleGap(0);

    for (int i = 0; i < NumInst; i++) begin
      for (int it = 0; it < RandIters; it++) randomTxn(i);
      pIf[i] = 1'b0;
      pD[i]  = 1'b0;
      applyStimulus(i);
    end

    resetMidServe(0);
    for (int i = 0; i < NumInst; i++) begin
      for (int it = 0; it < 8; it++) randomTxn(i);
      pIf[i] = 1'b0;
      pD[i]  = 1'b0;
      applyStimulus(i);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
